// File: rtl/i2s_audio_tx.sv
// I2S master transmitter: divides clk into BCLK/LRCLK and shifts out one
// buffered stereo pair per frame, with underflow reporting and lock gating.
module i2s_audio_tx #(
  parameter int DATA_W    = 16,
  parameter int SLOT_W    = 32,
  parameter int BCLK_HALF = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              bclk_o,
  output logic              lrclk_o,
  output logic              sdata_o,
  output logic              frame_start_o,
  output logic              underflow_o,
  output logic              underflow_sticky_o
);
  localparam int KW   = $clog2(2*SLOT_W);
  localparam int DIVW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  localparam logic [KW-1:0]   K_LAST = KW'(2*SLOT_W-1);
  localparam logic [KW-1:0]   K_ONE  = KW'(1);
  localparam logic [KW-1:0]   K_LEND = KW'(DATA_W);
  localparam logic [KW-1:0]   K_SLOT = KW'(SLOT_W);
  localparam logic [KW-1:0]   K_RBEG = KW'(SLOT_W+1);
  localparam logic [KW-1:0]   K_REND = KW'(SLOT_W+DATA_W);
  localparam logic [DIVW-1:0] D_TC   = DIVW'(BCLK_HALF-1);

  logic [1:0]        sync_q;
  logic [DIVW-1:0]   div_q;
  logic [KW-1:0]     k_q, k_d;
  logic              bclk_q, lr_q, sd_q, fs_q, uf_q, sticky_q;
  logic [DATA_W-1:0] lsh_q, rsh_q, hl_q, hr_q;
  logic              hv_q;
  logic              lk, tc, fall, load, accept;

  assign lk     = sync_q[1];
  assign tc     = (div_q == D_TC);
  assign fall   = lk & tc & bclk_q;
  assign k_d    = (k_q == K_LAST) ? '0 : k_q + K_ONE;
  assign load   = fall & (k_q == K_LAST);
  // A full holding register frees up on the very cycle it is loaded.
  assign s_ready = lk & (~hv_q | load);
  assign accept  = s_valid & s_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= '0;
      div_q    <= '0;
      k_q      <= K_LAST;
      bclk_q   <= 1'b0;
      lr_q     <= 1'b1;
      sd_q     <= 1'b0;
      fs_q     <= 1'b0;
      uf_q     <= 1'b0;
      sticky_q <= 1'b0;
      lsh_q    <= '0;
      rsh_q    <= '0;
      hl_q     <= '0;
      hr_q     <= '0;
      hv_q     <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
      fs_q   <= 1'b0;
      uf_q   <= 1'b0;
      if (!lk) begin
        // Lock lost: abort everything except the sticky underflow flag.
        div_q  <= '0;
        k_q    <= K_LAST;
        bclk_q <= 1'b0;
        lr_q   <= 1'b1;
        sd_q   <= 1'b0;
        lsh_q  <= '0;
        rsh_q  <= '0;
        hl_q   <= '0;
        hr_q   <= '0;
        hv_q   <= 1'b0;
      end else begin
        if (tc) begin
          div_q  <= '0;
          bclk_q <= ~bclk_q;
        end else begin
          div_q <= div_q + DIVW'(1);
        end
        if (fall) begin
          k_q  <= k_d;
          lr_q <= (k_d >= K_SLOT);
          if (load) begin
            lsh_q <= hv_q ? hl_q : '0;
            rsh_q <= hv_q ? hr_q : '0;
            fs_q  <= 1'b1;
            sd_q  <= 1'b0;
            if (!hv_q) begin
              uf_q     <= 1'b1;
              sticky_q <= 1'b1;
            end
          end else if (k_d >= K_ONE && k_d <= K_LEND) begin
            sd_q  <= lsh_q[DATA_W-1];
            lsh_q <= lsh_q << 1;
          end else if (k_d >= K_RBEG && k_d <= K_REND) begin
            sd_q  <= rsh_q[DATA_W-1];
            rsh_q <= rsh_q << 1;
          end else begin
            sd_q <= 1'b0;
          end
        end
        if (accept) begin
          hv_q <= 1'b1;
          hl_q <= s_left;
          hr_q <= s_right;
        end else if (load) begin
          hv_q <= 1'b0;
        end
      end
    end
  end

  assign bclk_o             = bclk_q;
  assign lrclk_o            = lr_q;
  assign sdata_o            = sd_q;
  assign frame_start_o      = fs_q;
  assign underflow_o        = uf_q;
  assign underflow_sticky_o = sticky_q;
endmodule

// File: tb/tb_i2s_audio_tx.sv
// Bench for i2s_audio_tx: randomized pairs, a queue-based scoreboard and a
// monitor that reassembles each 64-bit I2S frame from BCLK rises.
module tb_i2s_audio_tx;
  localparam int DW    = 16;
  localparam int SW    = 32;
  localparam int BH    = 3;
  localparam int FRAME = 2*SW*2*BH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pll_locked = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_left = '0;
  logic [DW-1:0] s_right = '0;
  logic          bclk_o, lrclk_o, sdata_o, frame_start_o, underflow_o, underflow_sticky_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  i2s_audio_tx #(.DATA_W(DW), .SLOT_W(SW), .BCLK_HALF(BH)) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .bclk_o(bclk_o), .lrclk_o(lrclk_o), .sdata_o(sdata_o),
    .frame_start_o(frame_start_o), .underflow_o(underflow_o),
    .underflow_sticky_o(underflow_sticky_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  // An I2S frame as heard on BCLK rises k=0..63 (MSB of the vector is k=0):
  // one idle bit after each LRCLK edge, the sample MSB first, then zero fill.
  function automatic logic [63:0] frame_bits(input logic [31:0] p);
    logic [DW-1:0] l, r;
    l = p[31:16];
    r = p[15:0];
    return {1'b0, l, 15'b0, 1'b0, r, 15'b0};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [31:0] q[$];
  logic [31:0] acc_item;
  logic [63:0] cap_sd, cap_lr, exp_sd;
  bit          acc_pend, exp_load, in_frame, sticky_m, bclk_prev;
  bit          mon_clear = 1'b1;
  int          nbits;
  longint      cyc = 0;
  longint      last_fs = -1;

  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (mon_clear) begin
      q.delete();
      acc_pend = 0;
      exp_load = 0;
      in_frame = 0;
      last_fs  = -1;
      if (!rst_n) sticky_m = 0;
    end else begin
      if (exp_load) begin
        chk("accept_only_on_load", frame_start_o, 1'b1);
        exp_load = 0;
      end
      if (underflow_o && !frame_start_o) chk("underflow_without_load", underflow_o, 1'b0);
      if (frame_start_o) begin
        if (last_fs >= 0) chk("frame_period", cyc - last_fs, FRAME);
        last_fs = cyc;
        chk("underflow_o", underflow_o, q.size() == 0);
        if (q.size() == 0) begin
          sticky_m = 1;
          exp_sd   = '0;
        end else begin
          exp_sd = frame_bits(q.pop_front());
        end
        chk("sticky_at_load", underflow_sticky_o, sticky_m);
        in_frame = 1;
        nbits    = 0;
        cap_sd   = '0;
        cap_lr   = '0;
      end
      if (acc_pend) q.push_back(acc_item);
      acc_pend = 0;
      if (s_valid && s_ready) begin
        if (q.size() > 0) exp_load = 1;
        acc_pend = 1;
        acc_item = {s_left, s_right};
      end
      if (in_frame && bclk_o && !bclk_prev) begin
        cap_sd[63-nbits] = sdata_o;
        cap_lr[63-nbits] = lrclk_o;
        nbits++;
        if (nbits == 64) begin
          chk("frame_sdata", cap_sd, exp_sd);
          chk("frame_lrclk", cap_lr, {32'h0, 32'hFFFF_FFFF});
          in_frame = 0;
        end
      end
    end
    bclk_prev = bclk_o;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
    s_left  = l;
    s_right = r;
    s_valid = 1'b1;
    for (int i = 0; i < 2*FRAME; i++) begin
      if (s_ready) begin
        @(negedge clk);
        s_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    timeout("send");
  endtask

  task automatic wait_fs(input int n);
    int got = 0;
    for (int i = 0; i < n*FRAME + 100; i++) begin
      @(negedge clk);
      if (frame_start_o) got++;
      if (got == n) return;
    end
    timeout("wait_frame_start");
  endtask

  task automatic wait_bits(input int b);
    for (int i = 0; i < 2*FRAME; i++) begin
      @(negedge clk);
      if (in_frame && nbits >= b) return;
    end
    timeout("wait_bits");
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_bclk"},    bclk_o, 1'b0);
    chk({tag, "_lrclk"},   lrclk_o, 1'b1);
    chk({tag, "_sdata"},   sdata_o, 1'b0);
    chk({tag, "_s_ready"}, s_ready, 1'b0);
    chk({tag, "_fs"},      frame_start_o, 1'b0);
    chk({tag, "_uf"},      underflow_o, 1'b0);
    chk({tag, "_sticky"},  underflow_sticky_o, 1'b0);
  endtask

  // Called on the negedge where rst_n was released.
  task automatic chk_restart();
    int tb = 0;
    int tf = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bclk_o && tb == 0) tb = i;
      if (frame_start_o && tf == 0) tf = i;
      if (tf != 0) break;
    end
    chk("first_bclk_rise", tb, 5);
    chk("first_frame_start", tf, 8);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0]   base;
    logic [DW-1:0] v;
    pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    reset_checks("por");
    rst_n = 1'b1;
    mon_clear = 1'b0;

    // basic frame
    fork
      send(16'hA5C3, 16'h5A3C);
      chk_restart();
    join
    wait_fs(1);

    // reset mid-frame at k=40 of the following (underflow) frame
    wait_bits(41);
    mon_clear = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    reset_checks("mid_rst");
    rst_n = 1'b1;
    mon_clear = 1'b0;
    chk_restart();

    // underflow frame is running; next pair plays in the next frame
    send(DW'($urandom), DW'($urandom));
    wait_fs(1);

    // backpressure: A fills holding, B waits for the load cycle
    send(DW'($urandom), DW'($urandom));
    send(DW'($urandom), DW'($urandom));
    wait_fs(1);

    // continuous ramp
    base = $urandom;
    for (int i = 0; i < 8; i++) begin
      v = base[DW-1:0] + DW'(i);
      send(v, ~v);
    end
    wait_fs(2);

    // lock loss mid-frame with a pair sitting in the holding register
    send(DW'($urandom), DW'($urandom));
    wait_bits(21);
    pll_locked = 1'b0;
    mon_clear = 1'b1;
    repeat (3) @(negedge clk);
    chk("lock_bclk",    bclk_o, 1'b0);
    chk("lock_lrclk",   lrclk_o, 1'b1);
    chk("lock_sdata",   sdata_o, 1'b0);
    chk("lock_s_ready", s_ready, 1'b0);
    repeat (10) @(negedge clk);
    chk("lock_sticky_kept", underflow_sticky_o, sticky_m);
    pll_locked = 1'b1;
    mon_clear = 1'b0;
    wait_fs(1);
    send(DW'($urandom), DW'($urandom));
    wait_fs(2);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2s_audio_tx.md
Name: i2s_audio_tx

Overview:
- Audio output stage that consumes the 18 MHz audio clock and `locked` flag from the audio PLL.
- Serialises stereo PCM samples from the FIR filter into an I2S stream for the board codec, which runs in slave mode.
- Acts as I2S master: generates BCLK and LRCLK from the single input clock, and accepts sample pairs through a valid/ready handshake.

Parameters:
- DATA_W, 16, sample width per channel. Constraint: 1 ≤ DATA_W ≤ SLOT_W-1.
- SLOT_W, 32, BCLK periods per channel slot.
- BCLK_HALF, 3, clk cycles per BCLK half-period (≥1). Defaults give 3 MHz BCLK and 46.875 kHz LRCLK from 18 MHz.

Ports:
- clk  in  1  audio clock (PLL output 0); all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- pll_locked  in  1  PLL lock flag; asynchronous to clk, synchronised internally.
- s_valid  in  1  sample pair valid.
- s_ready  out  1  block can accept a sample pair.
- s_left  in  DATA_W  left sample, two's complement.
- s_right  in  DATA_W  right sample, two's complement.
- bclk_o  out  1  I2S bit clock.
- lrclk_o  out  1  I2S word select: 0 = left, 1 = right.
- sdata_o  out  1  I2S serial data, MSB first.
- frame_start_o  out  1  one-clk pulse when a new frame's shift register is loaded.
- underflow_o  out  1  one-clk pulse when a frame is loaded with no sample available.
- underflow_sticky_o  out  1  set on any underflow; cleared only by reset.

Behaviour:
- **Reset (rst_n=0 at clk edge):**
  - Outputs: bclk_o=0, lrclk_o=1, sdata_o=0, s_ready=0, frame_start_o=0, underflow_o=0, underflow_sticky_o=0.
  - Internal: holding register empty; div_cnt=0; period index k=2*SLOT_W-1; sync flops=0.
- **Lock synchronisation:** pll_locked passes through a 2-flop synchroniser to give lk.
  - While lk=0: all state except underflow_sticky_o is held at reset values, and s_ready=0.
  - A drop of lk mid-frame aborts the frame. Outputs reach reset values on the clk edge after lk falls, i.e. ≤3 clk after pll_locked falls.
- **Divider (runs only when lk=1):**
  - div_cnt counts 0..BCLK_HALF-1.
  - At terminal count: div_cnt←0 and bclk_o toggles.
  - The first bclk_o rise occurs BCLK_HALF cycles after lk rises.
- **Falling-edge event** (bclk_o toggling 1→0), registered on the same edge:
  - k←(k+1) mod 2*SLOT_W.
  - lrclk_o←(new k ≥ SLOT_W).
  - sdata_o←bit for new k.
- **Bit mapping per period k:**
  - k=1..DATA_W: left bit DATA_W-k (MSB at k=1).
  - k=SLOT_W+1..SLOT_W+DATA_W: right bit, MSB first, same scheme.
  - All other k: 0.
  - Result: data lags each LRCLK edge by exactly one BCLK (I2S). Data changes on BCLK fall; the codec samples on BCLK rise.
- **Frame load:** when k wraps to 0, the left and right shift registers load from the holding register and the holding register becomes empty. frame_start_o pulses on that edge.
  - If the holding register is empty at load: both channels load 0, underflow_o pulses, and underflow_sticky_o sets.
- **Handshake:**
  - s_ready = lk & (holding empty | load on this cycle).
  - Transfer occurs when s_valid & s_ready.
  - If load and accept happen in the same cycle: load takes the old holding contents and the holding register takes the new sample. No loss, no underflow.
  - The holding register depth is one pair. A pair accepted at any time before a load is output in that load's frame.
  - The source must hold s_valid and data until s_ready is seen.
- Frame length is 2*SLOT_W*2*BCLK_HALF clk (384 at defaults). There is no drift or gap between frames.

Test Plan:
1. **Basic frame:** defaults, pll_locked=1, rst_n released; present s_left=16'hA5C3, s_right=16'h5A3C before the first load.
   - First bclk_o rise at clk 2+3 after reset release.
   - frame_start_o pulse, then sdata_o = 1010010111000011 on k=1..16 and 0 on k=17..31.
   - lrclk_o rises at k=32; 0101101000111100 on k=33..48.
   - Frame length is 384 clk.
2. **Underflow:** no s_valid after reset.
   - First load gives sdata_o=0 for the whole frame, one underflow_o pulse coincident with frame_start_o, and underflow_sticky_o=1.
   - A subsequent valid pair plays in the next frame; sticky stays 1.
3. **Backpressure:** accept pair A, then hold pair B valid.
   - s_ready=0 until the next load cycle; B is accepted on exactly that cycle (load plus accept together).
   - B plays in the following frame and no underflow occurs.
4. **Continuous stream:** a ramp source that is always valid for 8 frames.
   - Every frame carries the next ramp value; there is exactly one transfer per 384 clk and no underflow pulses.
5. **Lock loss mid-frame:** drop pll_locked at k=20.
   - Within 3 clk: bclk_o=0, lrclk_o=1, sdata_o=0, s_ready=0, and the holding register is cleared.
   - On relock, a clean frame starts with k=0 load; underflow_sticky_o is retained.
6. **Reset mid-frame:** rst_n=0 for 1 clk at k=40.
   - All outputs return to reset values on that edge, including underflow_sticky_o=0.
   - The restart timing matches scenario 1.
